dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  DBITS, 32, data width
  ABITS, 32, address width
  MAX_LOCK, 16, longest back-to-back grant run for port 1 under lock; range 2..255
REQ-002 Ports (name  direction  width  meaning) SHALL be, clock and reset first:
  clk  in  1  single clock, rising edge
  reset_n  in  1  asynchronous active-low reset
  m0_req  in  1  CPU port access request
  m0_we  in  1  CPU port write (1) / read (0)
  m0_addr  in  ABITS  CPU port word address
  m0_wdata  in  DBITS  CPU port write data
  m0_gnt  out  1  CPU port request accepted this cycle
  m0_rvalid  out  1  CPU port read data valid
  m0_rdata  out  DBITS  CPU port read data
  m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0_*, loader/debug port
  m1_lock  in  1  port 1 requests an uninterrupted run
  mem_en  out  1  memory access strobe
  mem_we  out  1  memory write enable
  mem_addr  out  ABITS  memory address
  mem_din  out  DBITS  memory write data
  mem_dout  in  DBITS  memory read data, valid the cycle after a read strobe

Function
REQ-003 At most one of m0_gnt/m1_gnt SHALL be high per cycle; grant is combinational from current requests and registered state.
REQ-004 When exactly one port requests, that port SHALL be granted in the same cycle.
REQ-005 FSM states: ARB, LOCKED.
REQ-006 In ARB with both requesting, the port not granted most recently SHALL win (round-robin); the last-grant register resets to port 1, so port 0 wins the first conflict.
REQ-007 ARB -> LOCKED when m1 is granted with m1_lock=1; lock counter loads 1.
REQ-008 In LOCKED, port 1 SHALL win every cycle it requests, and the counter increments on each m1 grant.
REQ-009 LOCKED -> ARB when m1_lock=0, when m1_req=0, or when the counter reaches MAX_LOCK with m0_req=1. In that exit cycle the arbiter SHALL apply ARB rules.
REQ-010 When forced out by MAX_LOCK, port 0 SHALL be granted in the exit cycle. The arbiter SHALL NOT re-enter LOCKED until port 0 has been granted once.
REQ-011 On a grant, mem_en=1, mem_we=<port>_we, and mem_addr and mem_din SHALL carry the winner's fields. With no grant, mem_en=0 and mem_we=0.
REQ-012 A granted read SHALL produce <port>_rvalid=1 exactly one cycle later, with <port>_rdata=mem_dout; a single registered tag selects the port.
REQ-013 Writes SHALL produce no rvalid.
REQ-014 rdata SHALL be driven with mem_dout for both ports. Consumers qualify it with rvalid only.
REQ-015 Back-to-back grants are allowed (throughput 1 access/cycle). An rvalid and a new grant MAY coincide.

Reset
REQ-016 Asserting reset_n low SHALL immediately force: FSM=ARB, lock counter=0, last-grant=port 1, read tag idle, both rvalid=0.
REQ-017 Grants and mem_en SHALL be 0 while reset_n is low.
REQ-018 A read granted in the cycle before reset asserts SHALL NOT produce rvalid.
REQ-019 Reset deassertion SHALL be synchronised externally; the block contains no synchroniser.

Structure
REQ-020 A shared package SHALL hold the FSM state encoding (ARB=0, LOCKED=1) and the port index constants (PORT_CPU=0, PORT_LDR=1).
REQ-021 A single sub-module, rr_pick2, SHALL implement the two-input round-robin pick (inputs: req vector and last-grant; output: one-hot grant).
REQ-022 The remaining logic (FSM, lock counter, read tag, muxing) SHALL live in dmem_arbiter.

Verification
REQ-023 Only m0 reads addr 0x10, with memory word 0x10 = 0xDEADBEEF: m0_gnt=1 in the same cycle; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
REQ-024 Both ports read every cycle, no lock, for 6 cycles: grants alternate m0, m1, m0, m1, m0, m1, each followed one cycle later by the matching rvalid.
REQ-025 m1_lock=1 and m1_req=1 held; m0_req raised at m1's 3rd grant (MAX_LOCK=16):
  m1 is granted 16 consecutive cycles;
  the 17th cycle grants m0;
  LOCKED is re-entered only after that m0 grant.
REQ-026 m1 writes 0x5 to addr 0x20 in locked mode, then drops m1_lock while m0 requests: m0 is granted the next cycle; no rvalid follows the write.
REQ-027 reset_n pulsed low asynchronously mid-cycle, one cycle after an m0 read grant: m0_rvalid stays 0; FSM is ARB; the first post-reset conflict grants m0.
REQ-028 Neither port requests for 10 cycles: mem_en=0 throughout; the arbiter state is unchanged.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared FSM state encoding and port index constants
package dmem_arbiter_pkg;
    typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} arb_state_t;
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bus bundle for the two requesting ports and the shared memory
// m0_* CPU port, m1_* loader/debug port (m1_lock requests an uninterrupted run),
// mem_* single-port memory side; slave = arbiter view, master = environment view
interface dmem_arbiter_if #(parameter int DBITS = 32, parameter int ABITS = 32);
    logic             m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [ABITS-1:0] m0_addr;
    logic [DBITS-1:0] m0_wdata, m0_rdata;
    logic             m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [ABITS-1:0] m1_addr;
    logic [DBITS-1:0] m1_wdata, m1_rdata;
    logic             mem_en, mem_we;
    logic [ABITS-1:0] mem_addr;
    logic [DBITS-1:0] mem_din, mem_dout;
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout
    );
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: two-input round-robin pick
// i_req request vector, i_last port granted most recently, o_gnt one-hot grant
module rr_pick2 import dmem_arbiter_pkg::*; (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);
    assign o_gnt = (&i_req) ? ((i_last == PORT_LDR) ? 2'b01 : 2'b10) : i_req;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter for a single-port data memory with port-1 lock runs
// clk rising-edge clock, reset_n async active-low reset, bus slave view of dmem_arbiter_if
module dmem_arbiter import dmem_arbiter_pkg::*; #(
    parameter int DBITS    = 32,
    parameter int ABITS    = 32,
    parameter int MAX_LOCK = 16
) (
    input logic          clk,
    input logic          reset_n,
    dmem_arbiter_if.slave bus
);
    localparam logic [7:0] L_MAX = 8'(MAX_LOCK);
    arb_state_t       r_state, w_state_n;
    logic [7:0]       r_cnt, w_cnt_n;
    logic             r_last, w_last_n;
    logic [1:0]       r_rd, w_rd_n;
    logic [1:0]       w_rr_gnt, w_gnt;
    logic             w_exit, w_arb, w_we;
    logic [ABITS-1:0] w_addr;
    logic [DBITS-1:0] w_din;
    rr_pick2 u_pick (
        .i_req  ({bus.m1_req, bus.m0_req}),
        .i_last (r_last),
        .o_gnt  (w_rr_gnt)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB;
            r_cnt   <= 8'd0;
            r_last  <= PORT_LDR;
            r_rd    <= 2'b00;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_last  <= w_last_n;
            r_rd    <= w_rd_n;
        end
    end
    always_comb begin
        // leaving LOCKED falls back to ARB rules in the same cycle; with last=port 1
        // a MAX_LOCK exit therefore hands the slot to port 0
        w_exit    = (r_state == LOCKED) &&
                    (!bus.m1_lock || !bus.m1_req || (r_cnt == L_MAX && bus.m0_req));
        w_arb     = (r_state == ARB) || w_exit;
        w_gnt     = !reset_n ? 2'b00 : (w_arb ? w_rr_gnt : 2'b10);
        w_state_n = ARB;
        w_cnt_n   = 8'd0;
        if (w_arb) begin
            w_state_n = (w_gnt[1] && bus.m1_lock) ? LOCKED : ARB;
            w_cnt_n   = (w_gnt[1] && bus.m1_lock) ? 8'd1 : 8'd0;
        end else begin
            w_state_n = LOCKED;
            w_cnt_n   = (r_cnt == L_MAX) ? r_cnt : r_cnt + 8'd1;
        end
        w_last_n  = w_gnt[1] ? PORT_LDR : (w_gnt[0] ? PORT_CPU : r_last);
        w_we      = (w_gnt[0] & bus.m0_we) | (w_gnt[1] & bus.m1_we);
        w_addr    = w_gnt[1] ? bus.m1_addr : bus.m0_addr;
        w_din     = w_gnt[1] ? bus.m1_wdata : bus.m0_wdata;
        // one-hot read tag: the granted port, only for reads
        w_rd_n    = w_gnt & ~{2{w_we}};
    end
    assign bus.m0_gnt    = w_gnt[0];
    assign bus.m1_gnt    = w_gnt[1];
    assign bus.mem_en    = |w_gnt;
    assign bus.mem_we    = w_we;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_din   = w_din;
    assign bus.m0_rvalid = r_rd[0];
    assign bus.m1_rvalid = r_rd[1];
    assign bus.m0_rdata  = bus.mem_dout;
    assign bus.m1_rdata  = bus.mem_dout;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] mem [256];
    dmem_arbiter_if #(.DBITS(32), .ABITS(32)) bus ();
    dmem_arbiter #(.DBITS(32), .ABITS(32), .MAX_LOCK(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_din;
            else bus.mem_dout <= mem[bus.mem_addr[7:0]];
        end
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic l1, input logic [31:0] a1,
                         input logic [31:0] d1);
        bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
        bus.m1_req = r1; bus.m1_we = w1; bus.m1_lock = l1; bus.m1_addr = a1; bus.m1_wdata = d1;
        #1;
    endtask
    initial begin
        for (int j = 0; j < 256; j++) mem[j] = 32'hA000_0000 + j;
        mem[16] = 32'hDEADBEEF;
        bus.mem_dout = '0;
        // reset held with both ports requesting
        drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
        tick;
        tick;
        chk("rst_m0_gnt", bus.m0_gnt, 0);
        chk("rst_m1_gnt", bus.m1_gnt, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_m0_rvalid", bus.m0_rvalid, 0);
        chk("rst_m1_rvalid", bus.m1_rvalid, 0);
        chk("rst_state", dut.r_state, ARB);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        tick;
        // both ports read every cycle: strict alternation starting with m0
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, i, 0, 1, 0, 0, 32'h40 + i, 0);
            chk("rr_gnt", {bus.m1_gnt, bus.m0_gnt}, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) begin
                chk("rr_rvalid", {bus.m1_rvalid, bus.m0_rvalid}, (i % 2 == 1) ? 2'b01 : 2'b10);
                chk("rr_rdata", (i % 2 == 1) ? bus.m0_rdata : bus.m1_rdata,
                    (i % 2 == 1) ? 32'hA000_0000 + i - 1 : 32'hA000_0040 + i - 1);
            end
            tick;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rr_last_rvalid", {bus.m1_rvalid, bus.m0_rvalid}, 2'b10);
        chk("rr_last_rdata", bus.m1_rdata, 32'hA000_0045);
        chk("rr_idle_mem_en", bus.mem_en, 0);
        tick;
        // lone m0 read of 0x10
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        chk("rd_m0_gnt", bus.m0_gnt, 1);
        chk("rd_m1_gnt", bus.m1_gnt, 0);
        chk("rd_mem_en", bus.mem_en, 1);
        chk("rd_mem_we", bus.mem_we, 0);
        chk("rd_mem_addr", bus.mem_addr, 32'h10);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rd_m0_rvalid", bus.m0_rvalid, 1);
        chk("rd_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
        chk("rd_m1_rvalid", bus.m1_rvalid, 0);
        tick;
        // lock run: m1 writes under lock, m0 joins at m1's 3rd grant
        for (int k = 1; k <= 18; k++) begin
            drive(k >= 3, 0, 32'h11, 0, 1, 1, 1, 32'h30, k);
            chk("lock_gnt", {bus.m1_gnt, bus.m0_gnt}, (k == 17) ? 2'b01 : 2'b10);
            tick;
            if (k == 17) chk("lock_exit_state", dut.r_state, ARB);
        end
        chk("lock_reenter_state", dut.r_state, LOCKED);
        // locked write of 0x5 to 0x20, then lock dropped while m0 reads 0x20
        drive(1, 0, 32'h20, 0, 1, 1, 1, 32'h20, 32'h5);
        chk("lw_gnt", {bus.m1_gnt, bus.m0_gnt}, 2'b10);
        chk("lw_mem_we", bus.mem_we, 1);
        chk("lw_mem_addr", bus.mem_addr, 32'h20);
        chk("lw_mem_din", bus.mem_din, 32'h5);
        tick;
        drive(1, 0, 32'h20, 0, 1, 0, 0, 32'h20, 32'h5);
        chk("unlock_gnt", {bus.m1_gnt, bus.m0_gnt}, 2'b01);
        chk("lw_no_rvalid", bus.m1_rvalid, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("unlock_m0_rvalid", bus.m0_rvalid, 1);
        chk("unlock_m0_rdata", bus.m0_rdata, 32'h5);
        chk("unlock_m1_rvalid", bus.m1_rvalid, 0);
        tick;
        // reset asserted mid-cycle while a read grant is pending
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        chk("prerst_m0_gnt", bus.m0_gnt, 1);
        #3 reset_n = 1'b0;
        #1;
        chk("inrst_m0_gnt", bus.m0_gnt, 0);
        chk("inrst_mem_en", bus.mem_en, 0);
        tick;
        chk("inrst_m0_rvalid", bus.m0_rvalid, 0);
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        chk("postrst_m0_rvalid", bus.m0_rvalid, 0);
        chk("postrst_state", dut.r_state, ARB);
        // reset clears an already-registered read tag immediately
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        tick;
        chk("tag_m0_rvalid", bus.m0_rvalid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_m0_rvalid", bus.m0_rvalid, 0);
        tick;
        reset_n = 1'b1;
        drive(1, 0, 32'h10, 0, 1, 0, 0, 32'h40, 0);
        chk("postrst_conflict_gnt", {bus.m1_gnt, bus.m0_gnt}, 2'b01);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // ten idle cycles leave state untouched
        for (int i = 0; i < 10; i++) begin
            chk("idle_mem_en", bus.mem_en, 0);
            tick;
        end
        chk("idle_state", dut.r_state, ARB);
        drive(1, 0, 32'h10, 0, 1, 0, 0, 32'h40, 0);
        chk("idle_conflict_gnt", {bus.m1_gnt, bus.m0_gnt}, 2'b10);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
